// File: rtl/final_adder_pkg.sv
// Shared widths, float bias and pairing FSM encoding for the final adder stages.
package final_adder_pkg;
  localparam int CORDIC_DATA_WIDTH = 22;
  localparam int FLOAT_DATA_WIDTH  = 32;
  localparam int FRAC_BITS         = 20;
  localparam int FLOAT_BIAS        = 127;

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } pair_state_t;
endpackage

// File: rtl/stage_3_fixed_to_float.sv
// Exact signed Q2.20 to IEEE-754 single conversion (combinational, no rounding needed).
module fixed_to_float
  import final_adder_pkg::*;
(
  input  logic [CORDIC_DATA_WIDTH-1:0] fixed,
  output logic [FLOAT_DATA_WIDTH-1:0]  result
);
  logic                         sign;
  logic [CORDIC_DATA_WIDTH-1:0] mag;
  logic [4:0]                   lead;
  logic [44:0]                  shifted;
  logic [7:0]                   exponent;

  // Sign/magnitude split, leading-one search and field packing.
  always_comb begin
    sign = fixed[CORDIC_DATA_WIDTH-1];
    // -2.0 (0x200000) negates to itself, which reads correctly as unsigned 2^21
    mag  = sign ? (22'd0 - fixed) : fixed;
    lead = 5'd0;
    for (int i = 0; i < CORDIC_DATA_WIDTH; i++) begin
      if (mag[i]) lead = 5'(i);
      else        lead = lead;
    end
    // Move the leading one to bit 23 so the bits beneath it form the mantissa
    shifted  = {23'd0, mag} << (5'd23 - lead);
    exponent = 8'(FLOAT_BIAS - FRAC_BITS) + {3'd0, lead};
    if (mag == 22'd0) result = 32'h0000_0000;
    else              result = {sign, exponent, shifted[22:0]};
  end
endmodule

// File: rtl/stage_3.sv
// Converts CORDIC cosines to float and pairs them with their squares for the adder tail.
// Optional macro STAGE_3_ORPHAN_FLUSH_EN: emit a lone trailing element as a half-zero pair.
module stage_3
  import final_adder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [CORDIC_DATA_WIDTH-1:0] result_in,
  input  logic [FLOAT_DATA_WIDTH-1:0]  squared_in,
  input  logic                         valid_in,
  input  logic                         pipeline_cleared_in,
  output logic [FLOAT_DATA_WIDTH-1:0]  cos_one,
  output logic [FLOAT_DATA_WIDTH-1:0]  cos_two,
  output logic [FLOAT_DATA_WIDTH-1:0]  sq_one,
  output logic [FLOAT_DATA_WIDTH-1:0]  sq_two,
  output logic                         pair_valid,
  output logic                         done
);
  logic [FLOAT_DATA_WIDTH-1:0] conv;
  logic                        a_valid;
  logic [FLOAT_DATA_WIDTH-1:0] a_cos;
  logic [FLOAT_DATA_WIDTH-1:0] a_sq;
  logic [FLOAT_DATA_WIDTH-1:0] slot_cos;
  logic [FLOAT_DATA_WIDTH-1:0] slot_sq;
  pair_state_t                 state;

  fixed_to_float u_conv (
    .fixed  (result_in),
    .result (conv)
  );

  // Stage A capture, pairing FSM and registered pair/done outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_FIRST;
      a_valid    <= 1'b0;
      a_cos      <= 32'h0000_0000;
      a_sq       <= 32'h0000_0000;
      slot_cos   <= 32'h0000_0000;
      slot_sq    <= 32'h0000_0000;
      cos_one    <= 32'h0000_0000;
      cos_two    <= 32'h0000_0000;
      sq_one     <= 32'h0000_0000;
      sq_two     <= 32'h0000_0000;
      pair_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      // The pulse drops on every edge, even while the pipeline is stalled
      pair_valid <= 1'b0;
      if (clk_en) begin
        a_valid <= valid_in;
        if (valid_in) begin
          a_cos <= conv;
          a_sq  <= squared_in;
        end
        done <= (state == WAIT_FIRST) & ~a_valid & pipeline_cleared_in;
        case (state)
          WAIT_FIRST: begin
            if (a_valid) begin
              slot_cos <= a_cos;
              slot_sq  <= a_sq;
              state    <= WAIT_SECOND;
            end
          end
          WAIT_SECOND: begin
            if (a_valid) begin
              cos_one    <= slot_cos;
              sq_one     <= slot_sq;
              cos_two    <= a_cos;
              sq_two     <= a_sq;
              pair_valid <= 1'b1;
              state      <= WAIT_FIRST;
            end else if (pipeline_cleared_in && !valid_in) begin
`ifdef STAGE_3_ORPHAN_FLUSH_EN
              cos_one    <= slot_cos;
              sq_one     <= slot_sq;
              cos_two    <= 32'h0000_0000;
              sq_two     <= 32'h0000_0000;
              pair_valid <= 1'b1;
`endif
              state      <= WAIT_FIRST;
            end
          end
          default: state <= WAIT_FIRST;
        endcase
      end
    end
  end
endmodule

// File: doc/stage_3.md
# stage_3

Consumes the CORDIC result stream delivered by stage 2: each valid 22-bit fixed-point cosine is converted exactly to IEEE-754 single and paired with its squared term. The two results belonging to one (x_one, x_two) request are collected and presented together as one registered pair for the floating-point multiply/add tail of the final adder.

## Interface
- CORDIC_DATA_WIDTH, 22: width of fixed-point cosine input, signed Q2.20.
- FLOAT_DATA_WIDTH, 32: IEEE-754 single width.
- FRAC_BITS, 20: fractional bits of cosine input.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- clk_en  in  1  advance enable; state, capture and conversion registers update only when 1.
- result_in  in  22  CORDIC cosine from stage 2, signed Q2.20.
- squared_in  in  32  float square paired with result_in.
- valid_in  in  1  result_in/squared_in valid this cycle.
- pipeline_cleared_in  in  1  CORDIC pipeline empty.
- cos_one, cos_two  out  32  float cosines, first and second of pair.
- sq_one, sq_two  out  32  float squares, first and second of pair.
- pair_valid  out  1  one-cycle pulse: pair outputs valid.
- done  out  1  no element held and pipeline cleared.

## Operation
- Conversion: v = result_in / 2^20. Zero -> 32'h00000000. Else sign = bit 21; magnitude = |v| as 22-bit unsigned (0x200000 -> 2^21, i.e. -2.0 exact); p = index of leading one (0..21); exponent = 127 + p - 20; mantissa = bits below leading one, left-aligned into 23 bits, zero-filled. Always exact, no rounding, no denormals/inf/NaN.
- squared_in passes through unmodified.
- Stage A (conversion register): on clk_en & valid_in capture converted cosine and squared_in plus a valid flag.
- Pairing FSM, driven by stage A valid:
  - WAIT_FIRST: element -> slot one, go WAIT_SECOND.
  - WAIT_SECOND: element -> slot two, load outputs cos_one/sq_one from slot one, cos_two/sq_two from element, pair_valid=1, go WAIT_FIRST.
- Orphan: pipeline_cleared_in=1 in WAIT_SECOND with no element in stage A or on valid_in: handled per Configuration.
- Simultaneous valid and cleared: valid wins; element captured, no orphan handling that cycle.
- done = (state==WAIT_FIRST) & ~stage A valid & pipeline_cleared_in, registered.
- Pair outputs hold their last value until next pair; only pair_valid pulses.

## Timing
- Reset (rst=0 at posedge): all outputs 0, state WAIT_FIRST, stage A valid 0, slots 0; reset mid-pair discards held element.
- Latency: second element sampled at edge k -> stage A at k, pair outputs and pair_valid=1 after edge k+1.
- pair_valid high exactly one clock; cleared on next posedge regardless of clk_en.
- clk_en=0: inputs ignored (valid_in dropped), state and slots hold.
- Throughput: one element per enabled cycle; back-to-back pairs sustained with no bubbles.

## Configuration
- STAGE_3_ORPHAN_FLUSH_EN defined: orphan emits a pair with slot one as first, cos_two=sq_two=32'h00000000, pair_valid=1, return to WAIT_FIRST.
- Undefined: orphan silently discarded, return to WAIT_FIRST, no pair_valid.

## Structure
- Package final_adder_pkg: CORDIC_DATA_WIDTH, FLOAT_DATA_WIDTH, FRAC_BITS, FLOAT_BIAS=127, FSM encodings WAIT_FIRST=1'b0, WAIT_SECOND=1'b1.
- Sub-module fixed_to_float: combinational sign/magnitude, leading-one detect, exponent/mantissa pack; instantiated once in front of stage A.

## Test plan
- Pair 22'h100000, 22'h080000 with squares 32'h40800000, 32'h41100000 -> pair_valid one cycle, cos_one=32'h3F800000, cos_two=32'h3F000000, sq_one/sq_two unchanged, two edges after second valid.
- Signed extremes: 22'h300000, 22'h200000 -> 32'hBF800000, 32'hC0000000; 22'h000000, 22'h000001 -> 32'h00000000, 32'h35800000.
- Three back-to-back pairs on consecutive cycles -> three pair_valid pulses two cycles apart, correct order, no loss.
- clk_en low between first and second element, valid_in pulsed while low -> pulse ignored; pair completes with next enabled valid.
- One element then pipeline_cleared_in=1 -> with macro: pair cos_two=0, pair_valid=1; without: no pair_valid, done=1 next cycle.
- rst=0 while in WAIT_SECOND -> all outputs 0; following pair 22'h100000, 22'h100000 gives cos_one=cos_two=32'h3F800000, no stale element.
